// File: rtl/pmp_seq_pkg.sv
// Shared types, encodings and the permission/domain decision rule used by the sequential PMP+DMP checker.
package pmp_seq_pkg;

  typedef enum logic [1:0] {
    ALLOW     = 2'd0,
    PERM_DENY = 2'd1,
    DOM_DENY  = 2'd2,
    NOMATCH   = 2'd3
  } cause_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    RESP  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    ADDR_OFF   = 2'd0,
    ADDR_TOR   = 2'd1,
    ADDR_NA4   = 2'd2,
    ADDR_NAPOT = 2'd3
  } addr_mode_e;

  // perm and request access share the encoding {x, w, r}
  typedef struct packed {
    logic       locked;
    logic [1:0] rsvd;
    addr_mode_e mode;
    logic [2:0] perm;
  } pmpcfg_t;

  typedef struct packed {
    logic [3:0] rsvd;
    logic [3:0] domain;
  } dmpcfg_t;

  localparam logic [1:0] PRIV_M = 2'b11;
  localparam logic [3:0] DOMI   = 4'd0;

  function automatic cause_e decide(input logic [2:0] access, input logic [2:0] perm,
                                    input logic [3:0] dom_cfg, input logic [3:0] cur);
    cause_e c;
    if ((access & perm) != access) begin
      c = PERM_DENY;
    end else if (dom_cfg != DOMI && cur != DOMI && cur != dom_cfg) begin
      c = DOM_DENY;
    end else begin
      c = ALLOW;
    end
    return c;
  endfunction

endpackage

// File: rtl/pmp_entry.sv
// Single PMP entry address matcher (OFF/TOR/NA4/NAPOT); pmpaddr holds address bits [PMP_LEN+1:2].
module pmp_entry
  import pmp_seq_pkg::*;
#(
  parameter int unsigned PLEN    = 34,
  parameter int unsigned PMP_LEN = 32
) (
  input  logic [PLEN-1:0]    addr_i,
  input  logic [PMP_LEN-1:0] conf_addr_i,
  input  logic [PMP_LEN-1:0] conf_addr_prev_i,
  input  logic [1:0]         conf_addr_mode_i,
  output logic               match_o
);

  logic [PMP_LEN-1:0] word_addr;
  logic [PMP_LEN-1:0] napot_mask;

  always_comb begin
    word_addr  = addr_i[PMP_LEN+1:2];
    // trailing ones plus the first zero mark the don't-care word bits of the region
    napot_mask = conf_addr_i ^ (conf_addr_i + PMP_LEN'(1));
    match_o    = 1'b0;
    case (conf_addr_mode_i)
      ADDR_TOR:   match_o = ({conf_addr_prev_i, 2'b00} <= addr_i) && (addr_i < {conf_addr_i, 2'b00});
      ADDR_NA4:   match_o = (word_addr == conf_addr_i);
      ADDR_NAPOT: match_o = (((word_addr ^ conf_addr_i) & ~napot_mask) == '0);
      default:    match_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/pmp_seq_checker.sv
// Multi-pass PMP+DMP checker: LANES entries per cycle, lowest qualifying index wins, early exit.
// Optional fault log enabled by defining PMP_SEQ_FAULT_LOG_EN.
module pmp_seq_checker
  import pmp_seq_pkg::*;
#(
  parameter int unsigned PLEN       = 34,
  parameter int unsigned PMP_LEN    = 32,
  parameter int unsigned NR_ENTRIES = 16,
  parameter int unsigned LANES      = 4,
  localparam int unsigned NE        = (NR_ENTRIES > 0) ? NR_ENTRIES : 1,
  localparam int unsigned IDX_W     = (NR_ENTRIES > 1) ? $clog2(NR_ENTRIES) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [PLEN-1:0]       req_addr_i,
  input  logic [2:0]            req_access_i,
  input  logic [1:0]            req_priv_i,
  input  logic [3:0]            req_dom_i,
  input  logic [NE*PMP_LEN-1:0] conf_addr_i,
  input  logic [NE*8-1:0]       pmpconf_i,
  input  logic [NE*8-1:0]       dmpconf_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic                  rsp_allow_o,
  output logic                  rsp_match_o,
  output logic [IDX_W-1:0]      rsp_idx_o,
  output logic [1:0]            rsp_cause_o,
  output logic                  busy_o,
  input  logic                  flt_clr_i,
  output logic [31:0]           flt_cnt_o,
  output logic [PLEN-1:0]       flt_addr_o
);

  localparam int unsigned NPASS_RAW = (NR_ENTRIES + LANES - 1) / LANES;
  localparam int unsigned NPASS     = (NPASS_RAW > 0) ? NPASS_RAW : 1;
  localparam int unsigned PASS_W    = (NPASS > 1) ? $clog2(NPASS) : 1;

  state_e state_q, state_d;

  logic [PLEN-1:0]   addr_q, addr_d;
  logic [2:0]        access_q, access_d;
  logic [1:0]        priv_q, priv_d;
  logic [3:0]        dom_q, dom_d;
  logic [PASS_W-1:0] pass_q, pass_d;
  logic              rsp_allow_q, rsp_allow_d;
  logic              rsp_match_q, rsp_match_d;
  logic [IDX_W-1:0]  rsp_idx_q, rsp_idx_d;
  cause_e            rsp_cause_q, rsp_cause_d;

  logic [LANES-1:0]              lane_en;
  logic [LANES-1:0]              lane_match;
  logic [LANES-1:0][31:0]        lane_idx;
  logic [LANES-1:0][31:0]        lane_sel;
  logic [LANES-1:0][31:0]        lane_prev_sel;
  logic [LANES-1:0][PMP_LEN-1:0] lane_addr;
  logic [LANES-1:0][PMP_LEN-1:0] lane_prev;
  pmpcfg_t [LANES-1:0]           lane_pcfg;
  dmpcfg_t [LANES-1:0]           lane_dcfg;
  logic                          unused_rsvd;

  logic        hit;
  int unsigned hit_lane;
  logic        last_pass;
  cause_e      hit_cause;

  // Per-lane operand mux; disabled lanes read entry 0 but can never qualify.
  always_comb begin
    unused_rsvd = 1'b0;
    for (int j = 0; j < LANES; j++) begin
      lane_idx[j]      = 32'(pass_q) * LANES + 32'(j);
      lane_en[j]       = lane_idx[j] < NR_ENTRIES;
      lane_sel[j]      = lane_en[j] ? lane_idx[j] : 32'd0;
      lane_prev_sel[j] = (lane_sel[j] == 32'd0) ? 32'd0 : lane_sel[j] - 32'd1;
      lane_addr[j]     = conf_addr_i[lane_sel[j]*PMP_LEN +: PMP_LEN];
      lane_prev[j]     = (lane_sel[j] == 32'd0) ? '0 : conf_addr_i[lane_prev_sel[j]*PMP_LEN +: PMP_LEN];
      lane_pcfg[j]     = pmpcfg_t'(pmpconf_i[lane_sel[j]*8 +: 8]);
      lane_dcfg[j]     = dmpcfg_t'(dmpconf_i[lane_sel[j]*8 +: 8]);
      unused_rsvd      = unused_rsvd ^ (^lane_pcfg[j].rsvd) ^ (^lane_dcfg[j].rsvd);
    end
  end

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    pmp_entry #(
      .PLEN    (PLEN),
      .PMP_LEN (PMP_LEN)
    ) u_entry (
      .addr_i           (addr_q),
      .conf_addr_i      (lane_addr[j]),
      .conf_addr_prev_i (lane_prev[j]),
      .conf_addr_mode_i (lane_pcfg[j].mode),
      .match_o          (lane_match[j])
    );
  end

  // Descending scan so the lowest qualifying lane is the one left standing.
  always_comb begin
    hit      = 1'b0;
    hit_lane = 0;
    for (int j = LANES - 1; j >= 0; j--) begin
      if (lane_en[j] && lane_match[j] && (priv_q != PRIV_M || lane_pcfg[j].locked)) begin
        hit      = 1'b1;
        hit_lane = j;
      end
    end
    hit_cause = decide(access_q, lane_pcfg[hit_lane].perm, lane_dcfg[hit_lane].domain, dom_q);
    last_pass = (pass_q == PASS_W'(NPASS - 1));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid_i) state_d = CHECK;
      CHECK:   if (hit || last_pass) state_d = RESP;
      RESP:    if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready_o = (state_q == IDLE);
    rsp_valid_o = (state_q == RESP);
    busy_o      = (state_q != IDLE);
  end

  always_comb begin
    addr_d      = addr_q;
    access_d    = access_q;
    priv_d      = priv_q;
    dom_d       = dom_q;
    pass_d      = pass_q;
    rsp_allow_d = rsp_allow_q;
    rsp_match_d = rsp_match_q;
    rsp_idx_d   = rsp_idx_q;
    rsp_cause_d = rsp_cause_q;
    if (state_q == IDLE && req_valid_i) begin
      addr_d   = req_addr_i;
      access_d = req_access_i;
      priv_d   = req_priv_i;
      dom_d    = req_dom_i;
      pass_d   = '0;
    end else if (state_q == CHECK) begin
      if (hit) begin
        rsp_allow_d = (hit_cause == ALLOW);
        rsp_match_d = 1'b1;
        rsp_idx_d   = IDX_W'(lane_idx[hit_lane]);
        rsp_cause_d = hit_cause;
      end else if (last_pass) begin
        // with no entries implemented everything is allowed outright
        rsp_allow_d = (NR_ENTRIES == 0) || (priv_q == PRIV_M);
        rsp_match_d = 1'b0;
        rsp_idx_d   = '0;
        rsp_cause_d = (NR_ENTRIES == 0) ? ALLOW : NOMATCH;
      end else begin
        pass_d = pass_q + PASS_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q      <= '0;
      access_q    <= '0;
      priv_q      <= '0;
      dom_q       <= '0;
      pass_q      <= '0;
      rsp_allow_q <= 1'b0;
      rsp_match_q <= 1'b0;
      rsp_idx_q   <= '0;
      rsp_cause_q <= ALLOW;
    end else begin
      addr_q      <= addr_d;
      access_q    <= access_d;
      priv_q      <= priv_d;
      dom_q       <= dom_d;
      pass_q      <= pass_d;
      rsp_allow_q <= rsp_allow_d;
      rsp_match_q <= rsp_match_d;
      rsp_idx_q   <= rsp_idx_d;
      rsp_cause_q <= rsp_cause_d;
    end
  end

  assign rsp_allow_o = rsp_allow_q;
  assign rsp_match_o = rsp_match_q;
  assign rsp_idx_o   = rsp_idx_q;
  assign rsp_cause_o = rsp_cause_q;

`ifdef PMP_SEQ_FAULT_LOG_EN
  logic [31:0]     flt_cnt_q, flt_cnt_d;
  logic [PLEN-1:0] flt_addr_q, flt_addr_d;

  always_comb begin
    flt_cnt_d  = flt_cnt_q;
    flt_addr_d = flt_addr_q;
    if (flt_clr_i) begin
      flt_cnt_d  = '0;
      flt_addr_d = '0;
    end else if (state_q == RESP && rsp_ready_i && !rsp_allow_q) begin
      if (flt_cnt_q != 32'hFFFF_FFFF) flt_cnt_d = flt_cnt_q + 32'd1;
      flt_addr_d = addr_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      flt_cnt_q  <= '0;
      flt_addr_q <= '0;
    end else begin
      flt_cnt_q  <= flt_cnt_d;
      flt_addr_q <= flt_addr_d;
    end
  end

  assign flt_cnt_o  = flt_cnt_q;
  assign flt_addr_o = flt_addr_q;
`else
  logic unused_flt_clr;
  assign unused_flt_clr = flt_clr_i;
  assign flt_cnt_o      = '0;
  assign flt_addr_o     = '0;
`endif

endmodule

// File: tb/tb_pmp_seq_checker.sv
// Directed bench for pmp_seq_checker (NR_ENTRIES=16, LANES=4); fault-log checks follow PMP_SEQ_FAULT_LOG_EN.
module tb_pmp_seq_checker;

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [33:0]   req_addr;
  logic [2:0]    req_access;
  logic [1:0]    req_priv;
  logic [3:0]    req_dom;
  logic [511:0]  conf_addr;
  logic [127:0]  pmpconf;
  logic [127:0]  dmpconf;
  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_allow;
  logic          rsp_match;
  logic [3:0]    rsp_idx;
  logic [1:0]    rsp_cause;
  logic          busy;
  logic          flt_clr;
  logic [31:0]   flt_cnt;
  logic [33:0]   flt_addr;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [2:0] ACC_R = 3'b001;
  localparam logic [2:0] ACC_W = 3'b010;
  localparam logic [1:0] PRV_U = 2'b00;
  localparam logic [1:0] PRV_M = 2'b11;

  pmp_seq_checker #(
    .PLEN       (34),
    .PMP_LEN    (32),
    .NR_ENTRIES (16),
    .LANES      (4)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_addr_i   (req_addr),
    .req_access_i (req_access),
    .req_priv_i   (req_priv),
    .req_dom_i    (req_dom),
    .conf_addr_i  (conf_addr),
    .pmpconf_i    (pmpconf),
    .dmpconf_i    (dmpconf),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_allow_o  (rsp_allow),
    .rsp_match_o  (rsp_match),
    .rsp_idx_o    (rsp_idx),
    .rsp_cause_o  (rsp_cause),
    .busy_o       (busy),
    .flt_clr_i    (flt_clr),
    .flt_cnt_o    (flt_cnt),
    .flt_addr_o   (flt_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_entry(input int idx, input logic [31:0] a, input logic [7:0] pc, input logic [7:0] dc);
    conf_addr[idx*32 +: 32] = a;
    pmpconf[idx*8 +: 8]     = pc;
    dmpconf[idx*8 +: 8]     = dc;
  endtask

  // Issue one request, check latency and response fields, optionally stall, then hand shake.
  task automatic run_case(input string tag, input logic [33:0] a, input logic [2:0] acc,
                          input logic [1:0] priv, input logic [3:0] dom,
                          input int exp_lat, input logic exp_allow, input logic exp_match,
                          input logic [3:0] exp_idx, input logic [1:0] exp_cause,
                          input int hold, input logic clr);
    int lat;
    @(negedge clk);
    req_valid  = 1'b1;
    req_addr   = a;
    req_access = acc;
    req_priv   = priv;
    req_dom    = dom;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 16) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_eq({tag, ".lat"},   64'(lat),       64'(exp_lat));
    check_eq({tag, ".allow"}, 64'(rsp_allow), 64'(exp_allow));
    check_eq({tag, ".match"}, 64'(rsp_match), 64'(exp_match));
    check_eq({tag, ".idx"},   64'(rsp_idx),   64'(exp_idx));
    check_eq({tag, ".cause"}, 64'(rsp_cause), 64'(exp_cause));
    if (hold > 0) begin
      repeat (hold) begin
        @(posedge clk);
        #1;
      end
      check_eq({tag, ".hold_valid"}, 64'(rsp_valid), 64'd1);
      check_eq({tag, ".hold_ready"}, 64'(req_ready), 64'd0);
      check_eq({tag, ".hold_allow"}, 64'(rsp_allow), 64'(exp_allow));
      check_eq({tag, ".hold_idx"},   64'(rsp_idx),   64'(exp_idx));
      check_eq({tag, ".hold_cause"}, 64'(rsp_cause), 64'(exp_cause));
    end
    rsp_ready = 1'b1;
    flt_clr   = clr;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    flt_clr   = 1'b0;
    check_eq({tag, ".idle"}, 64'(req_ready), 64'd1);
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_addr   = '0;
    req_access = '0;
    req_priv   = '0;
    req_dom    = '0;
    conf_addr  = '0;
    pmpconf    = '0;
    dmpconf    = '0;
    rsp_ready  = 1'b0;
    flt_clr    = 1'b0;

    // entry 9: NAPOT RW over 0x8000_0000 / 4 KiB, DOMI
    set_entry(9, 32'h2000_01FF, 8'h1B, 8'h00);

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst.req_ready", 64'(req_ready), 64'd1);
    check_eq("rst.rsp_valid", 64'(rsp_valid), 64'd0);
    check_eq("rst.busy",      64'(busy),      64'd0);
    check_eq("rst.allow",     64'(rsp_allow), 64'd0);
    check_eq("rst.flt_cnt",   64'(flt_cnt),   64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_case("napot9_read", 34'h0_8000_0010, ACC_R, PRV_U, 4'd0, 3, 1'b1, 1'b1, 4'd9, 2'd0, 0, 1'b0);

    // entry 1 OFF supplies the TOR base; entry 2 TOR read-only 0x8000_0000..0x8000_03FF
    set_entry(1, 32'h2000_0000, 8'h00, 8'h00);
    set_entry(2, 32'h2000_0100, 8'h09, 8'h00);
    run_case("tor2_write",    34'h0_8000_0010, ACC_W, PRV_U, 4'd0, 1, 1'b0, 1'b1, 4'd2, 2'd1, 0, 1'b0);
    run_case("tor2_top_read", 34'h0_8000_03FC, ACC_R, PRV_U, 4'd0, 1, 1'b1, 1'b1, 4'd2, 2'd0, 0, 1'b0);
    run_case("tor2_excl_end", 34'h0_8000_0400, ACC_R, PRV_U, 4'd0, 3, 1'b1, 1'b1, 4'd9, 2'd0, 0, 1'b0);
    set_entry(2, 32'h2000_0100, 8'h00, 8'h00);

    // entry 5: NA4 RWX at 0x9000_0000 owned by domain 3
    set_entry(5, 32'h2400_0000, 8'h17, 8'h03);
    run_case("dom_deny",  34'h0_9000_0000, ACC_R, PRV_U, 4'd4, 2, 1'b0, 1'b1, 4'd5, 2'd2, 0, 1'b0);
    run_case("dom_domi",  34'h0_9000_0000, ACC_R, PRV_U, 4'd0, 2, 1'b1, 1'b1, 4'd5, 2'd0, 0, 1'b0);
    run_case("dom_same",  34'h0_9000_0000, ACC_R, PRV_U, 4'd3, 2, 1'b1, 1'b1, 4'd5, 2'd0, 0, 1'b0);

    run_case("nomatch_m", 34'h0_1000_0000, ACC_R, PRV_M, 4'd0, 4, 1'b1, 1'b0, 4'd0, 2'd3, 0, 1'b0);
    run_case("nomatch_u", 34'h0_1000_0000, ACC_R, PRV_U, 4'd0, 4, 1'b0, 1'b0, 4'd0, 2'd3, 0, 1'b0);

    // entry 0: NAPOT R-only over 0x1000_0000 / 4 KiB, first unlocked then locked
    set_entry(0, 32'h0400_01FF, 8'h19, 8'h00);
    run_case("m_unlocked", 34'h0_1000_0020, ACC_W, PRV_M, 4'd0, 4, 1'b1, 1'b0, 4'd0, 2'd3, 0, 1'b0);
    set_entry(0, 32'h0400_01FF, 8'h99, 8'h00);
    run_case("m_locked",   34'h0_1000_0020, ACC_W, PRV_M, 4'd0, 1, 1'b0, 1'b1, 4'd0, 2'd1, 0, 1'b0);

    run_case("backpress", 34'h0_8000_0010, ACC_R, PRV_U, 4'd0, 3, 1'b1, 1'b1, 4'd9, 2'd0, 5, 1'b0);

    // reset while the entry-9 lookup is still in its second pass
    @(negedge clk);
    req_valid  = 1'b1;
    req_addr   = 34'h0_8000_0010;
    req_access = ACC_R;
    req_priv   = PRV_U;
    req_dom    = 4'd0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check_eq("rstmid.busy_before", 64'(busy), 64'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_eq("rstmid.rsp_valid", 64'(rsp_valid), 64'd0);
    check_eq("rstmid.req_ready", 64'(req_ready), 64'd1);
    check_eq("rstmid.busy",      64'(busy),      64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_case("flt_deny1", 34'h0_1100_0000, ACC_R, PRV_U, 4'd0, 4, 1'b0, 1'b0, 4'd0, 2'd3, 0, 1'b0);
    run_case("flt_deny2", 34'h0_1200_0000, ACC_R, PRV_U, 4'd0, 4, 1'b0, 1'b0, 4'd0, 2'd3, 0, 1'b0);
    run_case("flt_deny3", 34'h0_1300_0004, ACC_R, PRV_U, 4'd0, 4, 1'b0, 1'b0, 4'd0, 2'd3, 0, 1'b0);
`ifdef PMP_SEQ_FAULT_LOG_EN
    check_eq("flt.cnt3",  64'(flt_cnt),  64'd3);
    check_eq("flt.addr3", 64'(flt_addr), 64'h0_1300_0004);
`else
    check_eq("flt.cnt_tied",  64'(flt_cnt),  64'd0);
    check_eq("flt.addr_tied", 64'(flt_addr), 64'd0);
`endif
    run_case("flt_deny4_clr", 34'h0_1400_0000, ACC_R, PRV_U, 4'd0, 4, 1'b0, 1'b0, 4'd0, 2'd3, 0, 1'b1);
    check_eq("flt.cnt_clr",  64'(flt_cnt),  64'd0);
    check_eq("flt.addr_clr", 64'(flt_addr), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pmp_seq_checker.md
Name: pmp_seq_checker

Overview:
- Multi-cycle, parametrised PMP+DMP (JITDomain) permission checker with valid/ready request/response handshakes.
- Scales to NR_ENTRIES up to 64 by evaluating LANES entries per cycle with lowest-index priority, and stops early on the first qualifying match.
- Reports the permission result, the matched entry index and the denial cause.
- Sits between the MMU/LSU and the CSR file; the CSR file stalls pmpcfg/pmpaddr/dmpcfg writes while busy_o is high.

Parameters:
- CVA6Cfg, config_pkg::cva6_cfg_empty, core configuration
- PLEN, 34, physical address width
- PMP_LEN, 32, pmpaddr width
- NR_ENTRIES, 16, implemented entries, 0..64
- LANES, 4, entries evaluated per pass, 1..NR_ENTRIES; NR_ENTRIES need not be a multiple of LANES

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when valid&ready
- req_addr_i  in  PLEN  physical address
- req_access_i  in  riscv::pmp_access_t  access type
- req_priv_i  in  riscv::priv_lvl_t  privilege
- req_dom_i  in  riscv::dmp_domain_t  current domain
- conf_addr_i  in  NR_ENTRIES x PMP_LEN  pmpaddr array
- pmpconf_i  in  NR_ENTRIES x riscv::pmpcfg_t  pmp configs
- dmpconf_i  in  NR_ENTRIES x riscv::dmpcfg_t  domain configs
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed
- rsp_allow_o  out  1  access permitted
- rsp_match_o  out  1  an entry matched
- rsp_idx_o  out  max(1,$clog2(NR_ENTRIES))  matched entry index
- rsp_cause_o  out  2  pmp_seq_pkg::cause_e
- busy_o  out  1  state != IDLE
- flt_clr_i  in  1  clear fault log
- flt_cnt_o  out  32  fault count
- flt_addr_o  out  PLEN  last denied address

Behaviour:
- Reset values: all outputs 0 except req_ready_o=1; state IDLE; pass counter 0.
- FSM IDLE -> CHECK -> RESP -> IDLE.
  - IDLE: req_ready_o=1. On accept, register addr/access/priv/dom, pass=0, go to CHECK.
  - CHECK: evaluate entries pass*LANES+j, j=0..LANES-1.
    - Lanes with index >= NR_ENTRIES are disabled.
    - TOR previous address: conf_addr[idx-1], or 0 for idx 0.
  - RESP: rsp_valid_o=1. Response fields are stable until rsp_ready_i; then go to IDLE. No accept in RESP.
- Qualification: entry qualifies if matched and (priv != M or pmpcfg.locked).
- Lowest qualifying index in the current pass decides; latch the result and go to RESP.
- Decision for the qualifying entry:
  - PERM_DENY if (access & access_type) != access.
  - Else DOM_DENY if dom_cfg != DOMI and cur != DOMI and cur != dom_cfg.
  - Else ALLOW.
- Last pass with no qualifier: rsp_match_o=0, rsp_idx_o=0, cause NOMATCH; allow=1 if priv==M, else 0.
- Latency: accept edge T; response valid from edge T+k, where k = 1-based pass index that decided. Maximum ceil(NR_ENTRIES/LANES).
- NR_ENTRIES==0: CHECK lasts one cycle; allow=1, cause ALLOW, match=0.
- Configuration inputs must be stable while busy_o=1 (CSR stall). Checker behaviour is unspecified otherwise.
- Reset mid-CHECK or mid-RESP returns to IDLE immediately and drops the response.

Optional Feature:
- PMP_SEQ_FAULT_LOG_EN defined:
  - flt_cnt_o increments (saturating at 0xFFFFFFFF) on each response handshake with rsp_allow_o=0.
  - flt_addr_o captures that request's address.
  - flt_clr_i zeroes both, and wins over a simultaneous increment.
- Undefined: flt_cnt_o and flt_addr_o are tied to 0 and flt_clr_i is ignored.

Decomposition:
- Package pmp_seq_pkg holds:
  - cause_e {ALLOW=0, PERM_DENY=1, DOM_DENY=2, NOMATCH=3}
  - state_e {IDLE, CHECK, RESP}
  - function decide() implementing the permission/domain rule
- Sub-module: the existing pmp_entry, instantiated once per lane, with muxed conf_addr/prev/mode per pass. No other sub-module.

Test Plan:
- NR_ENTRIES=16, LANES=4, U-mode; entry 9 NAPOT RW over 0x8000_0000/4KiB, DOMI; read 0x8000_0010 -> rsp_valid 3 cycles after accept, allow=1, idx=9, cause ALLOW.
- Same setup, write to an entry 2 TOR R-only region -> valid after 1 cycle, allow=0, idx=2, cause PERM_DENY; entry 9 also matching is ignored.
- Entry 5 matching, dmpcfg.domain=3, req_dom=4 -> allow=0, cause DOM_DENY. Repeat with req_dom=DOMI -> allow=1.
- No match: M-mode -> allow=1, NOMATCH after 4 cycles; U-mode -> allow=0. M-mode with unlocked matching entry 0 (R-only, write) -> skipped, allow=1.
- rsp_ready_i low 5 cycles -> response stable, req_ready_o=0. Reset asserted in CHECK -> next cycle rsp_valid_o=0, req_ready_o=1.
- With PMP_SEQ_FAULT_LOG_EN: 3 denials -> flt_cnt_o=3, flt_addr_o=last address. flt_clr_i coincident with a 4th denial -> 0.
